// File: rtl/wb_slave_regfile.sv
// Wishbone classic slave: 16 x 32-bit register window with programmable wait states.
// Optional macro WB_SLAVE_ERR_EN: unmapped offsets complete with err_o instead of ack_o.
module wb_slave_regfile #(
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hCAFE_0001
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic        we_i,
    input  logic        sel_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic        adr_len_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [31:0] reg0_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    logic [5:0]  off_reg;
    logic [31:0] wdat_reg;
    logic        we_reg;
    logic        sel_reg;

    logic [31:0] regs_reg [15];
    logic [31:0] rd_vec   [16];
    logic [31:0] rdat_reg, rdat_next;
    logic        ack_reg, ack_next;
    logic [31:0] reg0_reg;

    logic        req;
    logic        hit;
    logic        accept;
    logic [5:0]  cur_off;
    logic [31:0] cur_dat;
    logic        cur_we;
    logic        cur_sel;
    logic        mapped;
    logic [3:0]  index;
    logic        enter_resp;
    logic        commit;

    // Address bits [1:0] select a byte within the word and are never decoded.
    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, adr_i[1:0]};

    assign req    = cyc_i & stb_i;
    assign hit    = ~adr_len_i | (adr_i[31:8] == BASE_ADR[31:8]);
    assign accept = (state_reg == ST_IDLE) & req & hit;

    // With zero wait states the commit edge is the accepting edge, so the
    // live bus is used while idle and the latched copy afterwards.
    assign cur_off = (state_reg == ST_IDLE) ? adr_i[7:2] : off_reg;
    assign cur_dat = (state_reg == ST_IDLE) ? dat_i      : wdat_reg;
    assign cur_we  = (state_reg == ST_IDLE) ? we_i       : we_reg;
    assign cur_sel = (state_reg == ST_IDLE) ? sel_i      : sel_reg;

    assign mapped     = (cur_off[5:4] == 2'b00);
    assign index      = cur_off[3:0];
    assign enter_resp = (state_next == ST_RESP);
    assign commit     = enter_resp & cur_we & cur_sel & mapped & (index != 4'hF);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    cnt_next   = WAIT_LOAD;
                    state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture on the accepting edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            off_reg  <= 6'd0;
            wdat_reg <= 32'd0;
            we_reg   <= 1'b0;
            sel_reg  <= 1'b0;
        end else if (accept) begin
            off_reg  <= adr_i[7:2];
            wdat_reg <= dat_i;
            we_reg   <= we_i;
            sel_reg  <= sel_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_regs
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    regs_reg[gi] <= 32'd0;
                end else if (commit && (index == 4'(gi))) begin
                    regs_reg[gi] <= cur_dat;
                end
            end
            assign rd_vec[gi] = regs_reg[gi];
        end
    endgenerate

    assign rd_vec[15] = ID_VALUE;

`ifdef WB_SLAVE_ERR_EN
    logic err_reg, err_next;
`endif

    // Output logic: responses are computed for the edge entering RESP
    always_comb begin
        ack_next  = 1'b0;
        rdat_next = 32'd0;
`ifdef WB_SLAVE_ERR_EN
        err_next  = 1'b0;
`endif
        if (enter_resp) begin
            if (mapped) begin
                ack_next = 1'b1;
                if (!cur_we) begin
                    rdat_next = rd_vec[index];
                end
            end else begin
`ifdef WB_SLAVE_ERR_EN
                err_next = 1'b1;
`else
                ack_next = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_reg  <= 1'b0;
            rdat_reg <= 32'd0;
            reg0_reg <= 32'd0;
        end else begin
            ack_reg  <= ack_next;
            rdat_reg <= rdat_next;
            reg0_reg <= regs_reg[0];
        end
    end

`ifdef WB_SLAVE_ERR_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end
    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

    assign ack_o  = ack_reg;
    assign dat_o  = rdat_reg;
    assign busy_o = (state_reg != ST_IDLE);
    assign reg0_o = reg0_reg;

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Directed bench for wb_slave_regfile: three instances cover wait states and base decode.
module tb_wb_slave_regfile;

`ifdef WB_SLAVE_ERR_EN
    localparam int UNM = 2;
`else
    localparam int UNM = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr_s [3];
    logic [31:0] wdat_s [3];
    logic        we_s [3];
    logic        sel_s [3];
    logic        stb_s [3];
    logic        cyc_s [3];
    logic        len_s [3];
    logic [31:0] dat_s [3];
    logic        ack_s [3];
    logic        err_s [3];
    logic        busy_s [3];
    logic [31:0] reg0_s [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_slave_regfile #(.BASE_ADR(32'h0000_0000), .WAIT_STATES(0), .ID_VALUE(32'hCAFE_0001)) u_ws0 (
        .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr_s[0]), .dat_i(wdat_s[0]), .we_i(we_s[0]),
        .sel_i(sel_s[0]), .stb_i(stb_s[0]), .cyc_i(cyc_s[0]), .adr_len_i(len_s[0]),
        .dat_o(dat_s[0]), .ack_o(ack_s[0]), .err_o(err_s[0]), .busy_o(busy_s[0]), .reg0_o(reg0_s[0]));

    wb_slave_regfile #(.BASE_ADR(32'h0000_0000), .WAIT_STATES(3), .ID_VALUE(32'hCAFE_0001)) u_ws3 (
        .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr_s[1]), .dat_i(wdat_s[1]), .we_i(we_s[1]),
        .sel_i(sel_s[1]), .stb_i(stb_s[1]), .cyc_i(cyc_s[1]), .adr_len_i(len_s[1]),
        .dat_o(dat_s[1]), .ack_o(ack_s[1]), .err_o(err_s[1]), .busy_o(busy_s[1]), .reg0_o(reg0_s[1]));

    wb_slave_regfile #(.BASE_ADR(32'h1000_0000), .WAIT_STATES(0), .ID_VALUE(32'hCAFE_0001)) u_base (
        .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr_s[2]), .dat_i(wdat_s[2]), .we_i(we_s[2]),
        .sel_i(sel_s[2]), .stb_i(stb_s[2]), .cyc_i(cyc_s[2]), .adr_len_i(len_s[2]),
        .dat_o(dat_s[2]), .ack_o(ack_s[2]), .err_o(err_s[2]), .busy_o(busy_s[2]), .reg0_o(reg0_s[2]));

    typedef struct {
        int          d;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        we;
        logic        sel;
        logic        len;
        int          resp;   // 0 none, 1 ack, 2 err
        logic [31:0] rdat;
        int          lat;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(int d, logic [31:0] adr, logic [31:0] wdat, logic we, logic sel,
                                logic len, int resp, logic [31:0] rdat, int lat);
        vec_t v;
        v.d = d; v.adr = adr; v.wdat = wdat; v.we = we; v.sel = sel; v.len = len;
        v.resp = resp; v.rdat = rdat; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic w, input logic s, input logic l);
        adr_s[d] = a; wdat_s[d] = wd; we_s[d] = w; sel_s[d] = s; len_s[d] = l;
        cyc_s[d] = 1'b1; stb_s[d] = 1'b1;
    endtask

    task automatic release_bus(input int d);
        cyc_s[d] = 1'b0; stb_s[d] = 1'b0; we_s[d] = 1'b0;
    endtask

    // One transfer: waits up to 12 edges for a response, then one idle edge.
    task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd, input logic w,
                        input logic s, input logic l, output int resp, output logic [31:0] rd,
                        output int lat, output int busy_n);
        drive(d, a, wd, w, s, l);
        resp = 0; rd = 32'd0; lat = 0; busy_n = 0;
        for (int c = 1; c <= 12 && resp == 0; c++) begin
            @(posedge clk); #1;
            if (busy_s[d]) busy_n++;
            if (ack_s[d] || err_s[d]) begin
                resp = (ack_s[d] && err_s[d]) ? 3 : (ack_s[d] ? 1 : 2);
                rd   = dat_s[d];
                lat  = c;
            end
        end
        release_bus(d);
        @(posedge clk); #1;
    endtask

    initial begin
        int          resp, lat, busy_n;
        logic [31:0] rd;

        for (int i = 0; i < 3; i++) begin
            adr_s[i] = '0; wdat_s[i] = '0; we_s[i] = 0; sel_s[i] = 0;
            stb_s[i] = 0; cyc_s[i] = 0; len_s[i] = 1;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack_s[0]}, 32'd0);
        check("rst_err", {31'd0, err_s[0]}, 32'd0);
        check("rst_busy", {31'd0, busy_s[0]}, 32'd0);
        check("rst_dat", dat_s[0], 32'd0);
        check("rst_reg0", reg0_s[0], 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // reg0_o follows the commit by one cycle
        drive(0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("reg0_ack", {31'd0, ack_s[0]}, 32'd1);
        check("reg0_before", reg0_s[0], 32'd0);
        release_bus(0);
        @(posedge clk); #1;
        check("reg0_ack_one_cycle", {31'd0, ack_s[0]}, 32'd0);
        check("reg0_after", reg0_s[0], 32'hDEAD_BEEF);
        $display("[TB] seq reg0 write: reg0_o=%h", reg0_s[0]);

        vecs.push_back(mk(0, 32'h0000_0004, 32'h1234_5678, 1, 1, 1, 1, 32'h0, 1));
        vecs.push_back(mk(0, 32'h0000_0004, 32'h0,         0, 1, 1, 1, 32'h1234_5678, 1));
        vecs.push_back(mk(0, 32'h0000_003C, 32'h0,         0, 1, 1, 1, 32'hCAFE_0001, 1));
        vecs.push_back(mk(0, 32'h0000_003C, 32'h0,         1, 1, 1, 1, 32'h0, 1));
        vecs.push_back(mk(0, 32'h0000_003C, 32'h0,         0, 1, 1, 1, 32'hCAFE_0001, 1));
        vecs.push_back(mk(0, 32'h0000_0008, 32'hFFFF_FFFF, 1, 0, 1, 1, 32'h0, 1));
        vecs.push_back(mk(0, 32'h0000_0008, 32'h0,         0, 1, 1, 1, 32'h0, 1));
        vecs.push_back(mk(0, 32'h0000_0080, 32'h5555_5555, 1, 1, 1, UNM, 32'h0, 1));
        vecs.push_back(mk(0, 32'h0000_0080, 32'h0,         0, 1, 1, UNM, 32'h0, 1));
        vecs.push_back(mk(0, 32'h0000_0040, 32'h0000_AAAA, 1, 1, 1, UNM, 32'h0, 1));
        vecs.push_back(mk(0, 32'h0000_0038, 32'hA5A5_A5A5, 1, 1, 1, 1, 32'h0, 1));
        vecs.push_back(mk(0, 32'h0000_003B, 32'h0,         0, 1, 1, 1, 32'hA5A5_A5A5, 1));
        vecs.push_back(mk(0, 32'h0000_003F, 32'h0,         0, 1, 1, 1, 32'hCAFE_0001, 1));
        vecs.push_back(mk(0, 32'hFFFF_FF04, 32'h0,         0, 1, 0, 1, 32'h1234_5678, 1));
        vecs.push_back(mk(0, 32'h0000_0104, 32'h0,         0, 1, 1, 0, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0000_0000, 32'h0,         0, 1, 1, 1, 32'hDEAD_BEEF, 1));
        vecs.push_back(mk(1, 32'h0000_0008, 32'h1111_2222, 1, 1, 1, 1, 32'h0, 4));
        vecs.push_back(mk(1, 32'h0000_0008, 32'h0,         0, 1, 1, 1, 32'h1111_2222, 4));
        vecs.push_back(mk(2, 32'h2000_0004, 32'h0,         0, 1, 1, 0, 32'h0, 0));
        vecs.push_back(mk(2, 32'h2000_0004, 32'hC0FF_EE00, 1, 1, 0, 1, 32'h0, 1));
        vecs.push_back(mk(2, 32'h1000_0004, 32'h0,         0, 1, 1, 1, 32'hC0FF_EE00, 1));
        vecs.push_back(mk(2, 32'h1000_0044, 32'h0,         0, 1, 1, UNM, 32'h0, 1));

        foreach (vecs[i]) begin
            xfer(vecs[i].d, vecs[i].adr, vecs[i].wdat, vecs[i].we, vecs[i].sel, vecs[i].len,
                 resp, rd, lat, busy_n);
            $display("[TB] vec %0d dut%0d adr=%h we=%0d resp=%0d lat=%0d dat=%h",
                     i, vecs[i].d, vecs[i].adr, vecs[i].we, resp, lat, rd);
            check($sformatf("vec%0d_resp", i), resp, vecs[i].resp);
            check($sformatf("vec%0d_dat", i), rd, vecs[i].rdat);
            if (vecs[i].resp != 0) begin
                check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
                check($sformatf("vec%0d_busy", i), busy_n, vecs[i].lat);
            end
        end

        // Abort during WAIT: cyc_i dropped, no ack, no write
        drive(1, 32'h0000_000C, 32'h0000_0099, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("abort_busy_wait", {31'd0, busy_s[1]}, 32'd1);
        @(posedge clk); #1;
        release_bus(1);
        resp = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ack_s[1] || err_s[1]) resp = 1;
        end
        check("abort_no_ack", resp, 0);
        check("abort_idle", {31'd0, busy_s[1]}, 32'd0);
        xfer(1, 32'h0000_000C, 32'h0, 1'b0, 1'b1, 1'b1, resp, rd, lat, busy_n);
        check("abort_reg_unchanged", rd, 32'd0);
        $display("[TB] seq abort: readback=%h", rd);

        // Asynchronous reset in the middle of WAIT
        drive(1, 32'h0000_0008, 32'h0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("arst_busy_before", {31'd0, busy_s[1]}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy_s[1]}, 32'd0);
        check("arst_ack", {31'd0, ack_s[1]}, 32'd0);
        check("arst_err", {31'd0, err_s[1]}, 32'd0);
        check("arst_dat", dat_s[1], 32'd0);
        check("arst_reg0", reg0_s[0], 32'd0);
        release_bus(1);
        $display("[TB] seq async reset: busy=%0d reg0=%h", busy_s[1], reg0_s[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
